// File: rtl/axi_pkg.sv
// Shared AXI channel definitions: response encodings and default AW/W/B payload structs.
package axi_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned UserWidth = 1;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    resp_t                resp;
    logic [UserWidth-1:0] user;
  } b_chan_t;

endpackage

// File: rtl/axi_write_sink_pkg.sv
// Beat-counter width and saturating increment shared by the write sink.
package axi_write_sink_pkg;

  localparam int unsigned BeatCntW = 9;
  localparam logic [BeatCntW-1:0] BeatCntMax = 9'd256;

  function automatic logic [BeatCntW-1:0] beat_inc(input logic [BeatCntW-1:0] c);
    return (c == BeatCntMax) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/axi_write_sink_fifo.sv
// Outstanding-AW FIFO; head visible combinationally, one-cycle push/pop.
// A push while full is dropped even when a pop happens in the same cycle.
module axi_write_sink_fifo #(
  parameter int unsigned Depth  = 4,
  parameter type         data_t = logic [7:0]
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  data_t push_dat_i,
  input  logic  pop_i,
  output data_t head_dat_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned OccW = $clog2(Depth + 1);

  data_t           r_mem [Depth];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [OccW-1:0] r_occ;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (r_occ == OccW'(Depth));
  assign empty_o    = (r_occ == '0);
  assign w_push     = push_i && !full_o;
  assign w_pop      = pop_i && !empty_o;
  assign head_dat_o = r_mem[r_rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
      else if (w_pop && !w_push) r_occ <= r_occ - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= push_dat_i;
  end

endmodule

// File: rtl/axi_write_sink.sv
// Terminating AXI write slave: queues AWs, drains each W burst, answers one B per AW in order.
// OKAY only when the burst length matches the AW len; counts completed and SLVERR transactions.
module axi_write_sink
  import axi_pkg::*;
  import axi_write_sink_pkg::*;
#(
  parameter type         aw_t    = axi_pkg::aw_chan_t,
  parameter type         w_t     = axi_pkg::w_chan_t,
  parameter type         b_t     = axi_pkg::b_chan_t,
  parameter int unsigned MaxTxns = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        aw_valid_i,
  input  aw_t         aw_chan_i,
  output logic        aw_ready_o,
  input  logic        w_valid_i,
  input  w_t          w_chan_i,
  output logic        w_ready_o,
  output logic        b_valid_o,
  output b_t          b_chan_o,
  input  logic        b_ready_i,
  output logic [31:0] txn_cnt_o,
  output logic [31:0] err_cnt_o
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [7:0]         len;
  } entry_t;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [BeatCntW-1:0]   r_cnt;
  logic                  r_err;
  resp_t                 r_resp;
  logic [31:0]           r_txn_cnt;
  logic [31:0]           r_err_cnt;
  entry_t                w_push_dat;
  entry_t                w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_len_hit;
  logic                  w_unused;

  assign aw_ready_o = !rst_i && !w_full;
  assign w_aw_hs    = aw_valid_i && aw_ready_o;
  assign w_w_hs     = w_valid_i && w_ready_o;
  assign w_len_hit  = (r_cnt == {1'b0, w_head.len});
  assign txn_cnt_o  = r_txn_cnt;
  assign err_cnt_o  = r_err_cnt;
  assign w_unused   = ^{aw_chan_i, w_chan_i};

  always_comb begin
    w_push_dat     = '0;
    w_push_dat.id  = aw_chan_i.id;
    w_push_dat.len = aw_chan_i.len;
  end

  axi_write_sink_fifo #(
    .Depth  (MaxTxns),
    .data_t (entry_t)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (w_aw_hs),
    .push_dat_i (w_push_dat),
    .pop_i      (w_pop),
    .head_dat_o (w_head),
    .full_o     (w_full),
    .empty_o    (w_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready_o   = 1'b0;
    b_valid_o   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: if (!w_empty) w_state_nxt = DATA;
      DATA: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_chan_i.last) w_state_nxt = RESP;
      end
      RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) begin
          w_pop       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    b_chan_o = '0;
    if (r_state == RESP) begin
      b_chan_o.id   = w_head.id;
      b_chan_o.resp = r_resp;
    end
  end

  // Resp is decided on the last beat using the count of beats before it (AXI len = beats-1).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_resp <= RESP_OKAY;
    end else begin
      if (r_state == IDLE && !w_empty) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (r_state == DATA && w_w_hs) begin
        r_cnt <= beat_inc(r_cnt);
        if (w_chan_i.last)  r_resp <= (w_len_hit && !r_err) ? RESP_OKAY : RESP_SLVERR;
        else if (w_len_hit) r_err  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_txn_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_pop) begin
      r_txn_cnt <= r_txn_cnt + 32'd1;
      if (r_resp == RESP_SLVERR) r_err_cnt <= r_err_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_axi_write_sink.sv
// Directed bench for axi_write_sink: drives on the falling edge, samples on the falling edge.
module tb_axi_write_sink;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aw_valid = 1'b0;
  aw_chan_t    aw_chan = '0;
  logic        aw_ready;
  logic        w_valid = 1'b0;
  w_chan_t     w_chan = '0;
  logic        w_ready;
  logic        b_valid;
  b_chan_t     b_chan;
  logic        b_ready = 1'b0;
  logic [31:0] txn_cnt;
  logic [31:0] err_cnt;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  b_chan_t     prev;
  int          n_b;
  int          n;
  logic        got;
  logic        have_prev;

  always #5 clk = ~clk;

  axi_write_sink #(
    .aw_t    (aw_chan_t),
    .w_t     (w_chan_t),
    .b_t     (b_chan_t),
    .MaxTxns (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .aw_valid_i (aw_valid),
    .aw_chan_i  (aw_chan),
    .aw_ready_o (aw_ready),
    .w_valid_i  (w_valid),
    .w_chan_i   (w_chan),
    .w_ready_o  (w_ready),
    .b_valid_o  (b_valid),
    .b_chan_o   (b_chan),
    .b_ready_i  (b_ready),
    .txn_cnt_o  (txn_cnt),
    .err_cnt_o  (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [7:0] len);
    int k = 0;
    aw_valid     = 1'b1;
    aw_chan      = '0;
    aw_chan.id   = id;
    aw_chan.len  = len;
    aw_chan.addr = 32'h1000;
    while (!aw_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("aw_handshake", 32'(aw_ready), 32'd1);
    @(negedge clk);
    aw_valid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic last);
    int k = 0;
    w_valid     = 1'b1;
    w_chan      = '0;
    w_chan.data = data;
    w_chan.strb = 4'hf;
    w_chan.last = last;
    while (!w_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("w_handshake", 32'(w_ready), 32'd1);
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic b_recv(output logic [3:0] id, output logic [1:0] resp);
    int k = 0;
    b_ready = 1'b1;
    while (!b_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("b_handshake", 32'(b_valid), 32'd1);
    id   = b_chan.id;
    resp = b_chan.resp;
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  initial begin
    // Reset state, held across clock edges.
    repeat (3) @(negedge clk);
    chk("rst_aw_ready", 32'(aw_ready), 32'd0);
    chk("rst_w_ready",  32'(w_ready),  32'd0);
    chk("rst_b_valid",  32'(b_valid),  32'd0);
    chk("rst_txn_cnt",  txn_cnt,       32'd0);
    chk("rst_err_cnt",  err_cnt,       32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("aw_ready_after_rst", 32'(aw_ready), 32'd1);
    chk("idle_w_ready", 32'(w_ready), 32'd0);

    // Single-beat burst: B one cycle after the last W handshake.
    aw_send(4'd3, 8'd0);
    w_send(32'h11111111, 1'b1);
    chk("b_latency", 32'(b_valid), 32'd1);
    chk("b_user", 32'(b_chan.user), 32'd0);
    b_recv(bid, bresp);
    chk("t1_id",   32'(bid),   32'd3);
    chk("t1_resp", 32'(bresp), 32'(RESP_OKAY));
    chk("t1_txn",  txn_cnt,    32'd1);
    chk("t1_b_drop", 32'(b_valid), 32'd0);

    // Four-beat burst with matching len.
    aw_send(4'd5, 8'd3);
    for (int i = 0; i < 4; i++) w_send(32'(i), 1'(i == 3));
    b_recv(bid, bresp);
    chk("t2_id",   32'(bid),   32'd5);
    chk("t2_resp", 32'(bresp), 32'(RESP_OKAY));
    chk("t2_txn",  txn_cnt,    32'd2);

    // Early last: one beat against len=1.
    aw_send(4'd1, 8'd1);
    w_send(32'h22, 1'b1);
    b_recv(bid, bresp);
    chk("t3_resp", 32'(bresp), 32'(RESP_SLVERR));
    chk("t3_err",  err_cnt,    32'd1);

    // Overlong burst: drained to last, then SLVERR.
    aw_send(4'd2, 8'd1);
    for (int i = 0; i < 3; i++) w_send(32'(i), 1'b0);
    chk("t4_no_b_in_drain", 32'(b_valid), 32'd0);
    w_send(32'h33, 1'b1);
    chk("t4_b_after_last", 32'(b_valid), 32'd1);
    b_recv(bid, bresp);
    chk("t4_id",   32'(bid),   32'd2);
    chk("t4_resp", 32'(bresp), 32'(RESP_SLVERR));
    chk("t4_err",  err_cnt,    32'd2);
    chk("t4_txn",  txn_cnt,    32'd4);

    // Fill the AW FIFO, then free one slot with a B.
    for (int i = 0; i < 4; i++) aw_send(4'(8 + i), 8'd0);
    aw_valid    = 1'b1;
    aw_chan     = '0;
    aw_chan.id  = 4'd12;
    chk("full_aw_ready", 32'(aw_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("full_aw_hold", 32'(aw_ready), 32'd0);
    w_send(32'h44, 1'b1);
    b_recv(bid, bresp);
    chk("full_id0", 32'(bid), 32'd8);
    chk("pop_aw_ready", 32'(aw_ready), 32'd1);
    @(negedge clk);
    aw_valid = 1'b0;
    chk("refull_aw_ready", 32'(aw_ready), 32'd0);
    for (int i = 9; i <= 12; i++) begin
      w_send(32'h55, 1'b1);
      b_recv(bid, bresp);
      chk("order_id",   32'(bid),   32'(i));
      chk("order_resp", 32'(bresp), 32'(RESP_OKAY));
    end
    chk("t5_txn", txn_cnt, 32'd9);

    // Reset mid-burst with two AWs queued.
    aw_send(4'd1, 8'd2);
    aw_send(4'd2, 8'd0);
    w_send(32'h66, 1'b0);
    chk("mid_in_data", 32'(w_ready), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_aw_ready", 32'(aw_ready), 32'd0);
    chk("mid_rst_w_ready",  32'(w_ready),  32'd0);
    chk("mid_rst_b_valid",  32'(b_valid),  32'd0);
    chk("mid_rst_txn",      txn_cnt,       32'd0);
    chk("mid_rst_err",      err_cnt,       32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_aw_ready_up", 32'(aw_ready), 32'd1);
    b_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (b_valid || w_ready) n++;
      @(negedge clk);
    end
    b_ready = 1'b0;
    chk("no_stale_b", 32'(n), 32'd0);
    aw_send(4'd7, 8'd0);
    w_send(32'h77, 1'b1);
    b_recv(bid, bresp);
    chk("post_rst_id",   32'(bid),   32'd7);
    chk("post_rst_resp", 32'(bresp), 32'(RESP_OKAY));
    chk("post_rst_txn",  txn_cnt,    32'd1);

    // Fresh counters, then 200 single-beat writes with random B stalls.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_b = 0;
    for (int i = 0; i < 200; i++) begin
      aw_send(4'(i), 8'd0);
      w_send(32'hcafebabe, 1'b1);
      got       = 1'b0;
      have_prev = 1'b0;
      n         = 0;
      while (!got && n < 100) begin
        b_ready = 1'($urandom_range(0, 1));
        if (b_valid) begin
          if (have_prev) chk("b_stable", 32'(b_chan), 32'(prev));
          prev      = b_chan;
          have_prev = 1'b1;
          if (b_ready) begin
            got   = 1'b1;
            bid   = b_chan.id;
            bresp = b_chan.resp;
          end
        end
        @(negedge clk);
        n++;
      end
      b_ready = 1'b0;
      chk("rnd_b_seen", 32'(got),   32'd1);
      chk("rnd_id",     32'(bid),   32'(i % 16));
      chk("rnd_resp",   32'(bresp), 32'(RESP_OKAY));
      if (got) n_b++;
    end
    chk("rnd_b_count", 32'(n_b), 32'd200);
    chk("rnd_txn",     txn_cnt,  32'd200);
    chk("rnd_err",     err_cnt,  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
